// File: rtl/matrix_addr_seq_if.sv
// rtl/matrix_addr_seq_if.sv - request/address-stream interface for matrix_addr_seq
//
// Purpose: bundles the run request (start, mode), the address beat stream
// (out_valid/out_ready/addr/last/rep_idx) and the status flags (busy, done).
// master: the sequencer (drives the stream and status, receives start/mode/out_ready).
// slave : the requester/consumer (drives start/mode/out_ready, receives the rest).
// Parameters: AW = address width, RW = pass-index width; must match the
// widths derived inside the sequencer from ROWS/COLS/REPS.

interface matrix_addr_seq_if #(
    parameter int AW = 4,
    parameter int RW = 2
);
    logic          start;
    logic          mode;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] addr;
    logic          last;
    logic [RW-1:0] rep_idx;
    logic          busy;
    logic          done;

    modport master (
        input  start, mode, out_ready,
        output out_valid, addr, last, rep_idx, busy, done
    );

    modport slave (
        output start, mode, out_ready,
        input  out_valid, addr, last, rep_idx, busy, done
    );
endinterface

// File: rtl/matrix_addr_seq.sv
// rtl/matrix_addr_seq.sv - multi-pass matrix element address sequencer
//
// Purpose: on start, emits ROWS*COLS*REPS element addresses (r*COLS + c) over
// a valid/ready stream, REPS full passes of the matrix, column walk (r fastest)
// or row walk (c fastest). Addresses are built incrementally with adders only.
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset, aborts any run (no done)
//   bus.start  - run request, sampled only in IDLE
//   bus.mode   - 0 = column walk, 1 = row walk; latched at start
//   bus.out_ready / bus.out_valid / bus.addr / bus.last / bus.rep_idx - beat stream
//   bus.busy   - high while the run is in progress
//   bus.done   - one-cycle pulse in the cycle after the final beat is accepted
// Configuration: macro MATRIX_ADDR_SEQ_ROWWALK_EN enables mode selection;
// without it mode is ignored and traversal is always column walk.

module matrix_addr_seq #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int REPS = 3
) (
    input  logic                clk,
    input  logic                rst,
    matrix_addr_seq_if.master   bus
);
    localparam int AW  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam int RW  = (REPS > 1) ? $clog2(REPS) : 1;
    localparam int RBW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CBW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [RBW-1:0] ROW_MAX  = RBW'(ROWS - 1);
    localparam logic [CBW-1:0] COL_MAX  = CBW'(COLS - 1);
    localparam logic [RW-1:0]  REP_MAX  = RW'(REPS - 1);
    localparam logic [AW-1:0]  COL_STEP = AW'(COLS);
    localparam logic           ONE_BEAT = (ROWS * COLS * REPS == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t         r_state;
    logic [RBW-1:0] r_row;
    logic [CBW-1:0] r_col;
    logic [RW-1:0]  r_rep;
    logic [AW-1:0]  r_addr;
    logic           r_mode;
    logic           r_valid;
    logic           r_last;
    logic           r_busy;
    logic           r_done;

    logic           w_mode_in;
    logic [RBW-1:0] w_row_nxt;
    logic [CBW-1:0] w_col_nxt;
    logic [RW-1:0]  w_rep_nxt;
    logic [AW-1:0]  w_addr_nxt;
    logic           w_last_nxt;
    logic           w_row_end;
    logic           w_col_end;
    logic           w_rep_end;

`ifdef MATRIX_ADDR_SEQ_ROWWALK_EN
    assign w_mode_in = bus.mode;
`else
    // Port kept for drop-in compatibility; its value never reaches the walk.
    assign w_mode_in = bus.mode & 1'b0;
`endif

    assign w_row_end = (r_row == ROW_MAX);
    assign w_col_end = (r_col == COL_MAX);
    assign w_rep_end = (r_rep == REP_MAX);

    // Position of the beat that follows the one currently presented.
    always_comb begin
        w_row_nxt  = r_row;
        w_col_nxt  = r_col;
        w_rep_nxt  = r_rep;
        w_addr_nxt = r_addr;
        if (w_row_end && w_col_end) begin
            // Bottom-right element ends a pass in both walk orders.
            w_row_nxt  = '0;
            w_col_nxt  = '0;
            w_addr_nxt = '0;
            w_rep_nxt  = w_rep_end ? '0 : r_rep + RW'(1);
        end else if (!r_mode) begin
            if (w_row_end) begin
                // Top of the next column: with r = 0 the address is just c.
                w_row_nxt  = '0;
                w_col_nxt  = r_col + CBW'(1);
                w_addr_nxt = AW'(r_col) + AW'(1);
            end else begin
                w_row_nxt  = r_row + RBW'(1);
                w_addr_nxt = r_addr + COL_STEP;
            end
        end else begin
            // Row walk is linear: wrapping c into the next row is still +1.
            if (w_col_end) begin
                w_col_nxt = '0;
                w_row_nxt = r_row + RBW'(1);
            end else begin
                w_col_nxt = r_col + CBW'(1);
            end
            w_addr_nxt = r_addr + AW'(1);
        end
        w_last_nxt = (w_row_nxt == ROW_MAX) && (w_col_nxt == COL_MAX) &&
                     (w_rep_nxt == REP_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_rep   <= '0;
            r_addr  <= '0;
            r_mode  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_rep   <= '0;
                        r_addr  <= '0;
                        r_mode  <= w_mode_in;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= ONE_BEAT;
                    end
                end
                S_RUN: begin
                    if (r_valid && bus.out_ready) begin
                        if (r_last) begin
                            r_state <= S_FIN;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_rep   <= '0;
                            r_addr  <= '0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row  <= w_row_nxt;
                            r_col  <= w_col_nxt;
                            r_rep  <= w_rep_nxt;
                            r_addr <= w_addr_nxt;
                            r_last <= w_last_nxt;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.addr      = r_addr;
    assign bus.last      = r_last;
    assign bus.rep_idx   = r_rep;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
